// File: rtl/ahb_mem_slave_pkg.sv
// Shared types and constants for the AHB-Lite memory slave and its banks.
package definesPkg;

  // Transfer type presented in the address phase
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    NON_SEQ = 2'd2,
    SEQ     = 2'd3
  } htrans_t;

  // Burst kind; carried for visibility only, the slave decodes every beat on its own
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  // Transfer size; anything above a word is rejected with ERROR
  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_t;

  localparam int NUM_OF_SLAVES = 2;
  localparam int BANK_SIZE     = 1024;

  // Slave data-phase state
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_t;

  // Little-endian byte lanes touched by a transfer of the given size and offset
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] offs);
    case (size)
      3'd0:    return 4'b0001 << offs;
      3'd1:    return offs[1] ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle shared by the master VIP, the monitor and the memory slave.
interface ahb_interface;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_mem_slave_bank.sv
// One 1 KB bank: 256 words with byte-enabled synchronous write and combinational read.
module ahb_mem_bank (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem [256];

  // Byte-lane write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: banked RAM with read-only ID words, wait states and ERROR responses.
module ahb_mem_slave
  import definesPkg::*;
#(
  parameter int          NUM_OF_SLAVES = definesPkg::NUM_OF_SLAVES,
  parameter int          WAIT_STATES   = 0,
  parameter logic [31:0] ID_VALUE      = 32'hA5A5_0000
) (
  input logic         HCLK,
  input logic         reset,
  ahb_interface.slave bus
);

  localparam int BANK_BITS = (NUM_OF_SLAVES > 1) ? $clog2(NUM_OF_SLAVES) : 1;

  slave_state_t         state;
  logic [2:0]           wait_cnt;
  logic                 hready_q;
  logic                 hresp_q;
  logic                 write_q;
  logic [3:0]           be_q;
  logic [BANK_BITS-1:0] bank_q;
  logic [7:0]           word_q;

  logic                 accept;
  logic                 out_of_range;
  logic                 id_write;
  logic                 bad_size;
  logic                 misaligned;
  logic                 err_flag;
  logic                 mem_we;
  logic [31:0]          rd_word;
  logic [31:0]          bank_rdata [NUM_OF_SLAVES];

  wire unused_hburst = ^bus.HBURST;

  // Address-phase decode: a valid transfer is taken only while the previous data phase is ending
  always_comb begin
    accept       = hready_q && bus.HSEL && bus.HTRANS[1];
    out_of_range = bus.HADDR >= 32'(NUM_OF_SLAVES * BANK_SIZE);
    id_write     = bus.HWRITE && (bus.HADDR[9:0] <= 10'd3);
    bad_size     = bus.HSIZE > 3'd2;
    misaligned   = ((bus.HSIZE == 3'(SIZE_HALF)) && bus.HADDR[0]) ||
                   ((bus.HSIZE == 3'(SIZE_WORD)) && (bus.HADDR[1:0] != 2'b00));
    err_flag     = out_of_range || id_write || bad_size || misaligned;
  end

  // Slave FSM with registered HREADY/HRESP; errors skip the wait states
  always_ff @(posedge HCLK or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      write_q  <= 1'b0;
      be_q     <= 4'b0000;
      bank_q   <= '0;
      word_q   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept) begin
            write_q  <= bus.HWRITE;
            be_q     <= byte_enable(bus.HSIZE, bus.HADDR[1:0]);
            bank_q   <= bus.HADDR[10 +: BANK_BITS];
            word_q   <= bus.HADDR[9:2];
            wait_cnt <= 3'd0;
            if (err_flag) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              hready_q <= 1'b0;
              hresp_q  <= 1'b0;
            end else begin
              state    <= ST_DATA;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
            end
          end else begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'(WAIT_STATES - 1)) begin
            state    <= ST_DATA;
            wait_cnt <= 3'd0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  // The write lands on the edge that closes the DATA cycle; ID words are never stored
  assign mem_we = (state == ST_DATA) && write_q && (word_q != 8'd0);

  for (genvar b = 0; b < NUM_OF_SLAVES; b++) begin : g_bank
    ahb_mem_bank u_bank (
      .clk   (HCLK),
      .we    (mem_we && (bank_q == BANK_BITS'(b))),
      .be    (be_q),
      .addr  (word_q),
      .wdata (bus.HWDATA),
      .rdata (bank_rdata[b])
    );
  end

  // Read path returns the whole word; word 0 of each bank is the bank's ID constant
  always_comb begin
    rd_word = bank_rdata[bank_q];
    if (word_q == 8'd0) rd_word = ID_VALUE + 32'(bank_q);
  end

  assign bus.HRDATA = ((state == ST_DATA) && !write_q) ? rd_word : 32'd0;
  assign bus.HREADY = hready_q;
  assign bus.HRESP  = hresp_q;

endmodule
